// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the 8-phase timing-pulse generator.
// Optional feature macro: PULSE_GEN_SELF_CORRECT_EN (uses is_onehot).
package pulse_gen_pkg;

  localparam int unsigned PHASE_CNT = 8;

  typedef logic [PHASE_CNT-1:0] phase_vec_t;

  localparam phase_vec_t PHASE_T0 = 8'b0000_0001;

  // True when exactly one bit of the ring is set (all-zero is not one-hot).
  function automatic logic is_onehot(input phase_vec_t v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < PHASE_CNT; i++) begin
      cnt += int'(v[i]);
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/pulse_gen.sv
// 8-phase beat distributor: one-hot ring register driving strobes T0..T7.
// Optional feature macro: PULSE_GEN_SELF_CORRECT_EN -- when defined, a
// ring that is not one-hot is reloaded with the reset phase on the next edge.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned NUM_PHASES  = 8,
  parameter int unsigned RESET_PHASE = 0
) (
  input  logic CLK,
  input  logic CLRn,
  output logic T0,
  output logic T1,
  output logic T2,
  output logic T3,
  output logic T4,
  output logic T5,
  output logic T6,
  output logic T7
);

  // The port list hard-codes eight strobes, so any other ring size is rejected.
  if (NUM_PHASES != PHASE_CNT) begin : g_bad_num_phases
    $error("pulse_gen: NUM_PHASES must be 8");
  end
  if (RESET_PHASE >= PHASE_CNT) begin : g_bad_reset_phase
    $error("pulse_gen: RESET_PHASE must be in 0..7");
  end

  localparam phase_vec_t RESET_VEC = PHASE_T0 << RESET_PHASE;

  phase_vec_t ring_q;
  phase_vec_t ring_d;

  // Next ring value: rotate left by one (T7 wraps to T0).
  always_comb begin
    ring_d = {ring_q[PHASE_CNT-2:0], ring_q[PHASE_CNT-1]};
`ifdef PULSE_GEN_SELF_CORRECT_EN
    if (!is_onehot(ring_q)) begin
      ring_d = RESET_VEC;
    end
`endif
  end

  // Ring register: synchronous active-high clear has priority over rotation.
  always_ff @(posedge CLK) begin
    if (CLRn) begin
      ring_q <= RESET_VEC;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign T0 = ring_q[0];
  assign T1 = ring_q[1];
  assign T2 = ring_q[2];
  assign T3 = ring_q[3];
  assign T4 = ring_q[4];
  assign T5 = ring_q[5];
  assign T6 = ring_q[6];
  assign T7 = ring_q[7];

endmodule

// File: tb/tb_pulse_gen.sv
// Self-checking bench for pulse_gen: phase-index model plus directed literals.
module tb_pulse_gen;

  logic CLK = 1'b0;
  logic CLRn;
  logic T0, T1, T2, T3, T4, T5, T6, T7;

  pulse_gen #(
    .NUM_PHASES (8),
    .RESET_PHASE(0)
  ) dut (
    .CLK (CLK),
    .CLRn(CLRn),
    .T0  (T0),
    .T1  (T1),
    .T2  (T2),
    .T3  (T3),
    .T4  (T4),
    .T5  (T5),
    .T6  (T6),
    .T7  (T7)
  );

  always #5 CLK = ~CLK;

  int vectors   = 0;
  int miscompares = 0;

  // Model: the current phase is just an integer index 0..7.
  int   phase       = 0;
  logic model_valid = 1'b0;
  logic skip_cmp    = 1'b0;
  logic corrupt     = 1'b0;

  function automatic logic [7:0] outs();
    return {T7, T6, T5, T4, T3, T2, T1, T0};
  endfunction

  function automatic logic [7:0] model_vec();
    logic [7:0] v;
    v = '0;
    v[phase] = 1'b1;
    return v;
  endfunction

  // Model update on every rising edge.
  always @(posedge CLK) begin
    if (CLRn === 1'b1) begin
      phase = 0;
      model_valid = 1'b1;
    end else if (corrupt) begin
      phase = 0;
    end else if (model_valid) begin
      phase = (phase + 1) % 8;
    end
  end

  // Continuous compare of outputs against the model, away from the active edge.
  always @(negedge CLK) begin
    if (model_valid && !skip_cmp) begin
      vectors++;
      if (outs() !== model_vec()) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t got=%b expected=%b", $time, outs(), model_vec());
      end
    end
  end

  task automatic check_lit(input string name, input logic [7:0] exp);
    vectors++;
    if (outs() !== exp) begin
      miscompares++;
      $display("FAIL %s got=%b expected=%b", name, outs(), exp);
    end
  endtask

  task automatic step(input logic clr);
    CLRn = clr;
    @(posedge CLK);
    #1;
  endtask

  int last_rise;
  int cyc;
  int intervals;
  logic prev_t0;

  initial begin
    CLRn = 1'b1;
    @(negedge CLK);

    // Reset held for two edges.
    step(1'b1);
    check_lit("reset_edge1", 8'b0000_0001);
    step(1'b1);
    check_lit("reset_edge2", 8'b0000_0001);

    // Free run 16 clocks: T1..T7, T0, T1..T7, T0.
    step(1'b0);
    check_lit("run_first_T1", 8'b0000_0010);
    for (int k = 2; k <= 16; k++) begin
      step(1'b0);
      if (k == 7)  check_lit("run_T7", 8'b1000_0000);
      if (k == 8)  check_lit("wrap_T7_to_T0", 8'b0000_0001);
      if (k == 11) check_lit("run_T3", 8'b0000_1000);
      if (k == 16) check_lit("run_end_T0", 8'b0000_0001);
    end

    // Mid-sequence reset while T4 is high.
    for (int k = 0; k < 4; k++) step(1'b0);
    check_lit("pre_reset_T4", 8'b0001_0000);
    step(1'b1);
    check_lit("mid_reset_T0", 8'b0000_0001);
    step(1'b0);
    check_lit("post_reset_T1", 8'b0000_0010);

    // Reset held three edges from T6.
    for (int k = 0; k < 5; k++) step(1'b0);
    check_lit("pre_hold_T6", 8'b0100_0000);
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      check_lit("hold_reset_T0", 8'b0000_0001);
    end

    // Periodicity of T0 rises over 10+ periods (bounded cycle count).
    CLRn = 1'b0;
    prev_t0 = T0;
    last_rise = 0;
    intervals = 0;
    for (cyc = 1; cyc <= 82; cyc++) begin
      @(posedge CLK);
      #1;
      if (T0 && !prev_t0) begin
        if (last_rise != 0) begin
          intervals++;
          vectors++;
          if (cyc - last_rise != 8) begin
            miscompares++;
            $display("FAIL t0_period got=%0d expected=8", cyc - last_rise);
          end
        end
        last_rise = cyc;
      end
      prev_t0 = T0;
    end
    vectors++;
    if (intervals < 9) begin
      miscompares++;
      $display("FAIL t0_interval_count got=%0d expected>=9", intervals);
    end

`ifdef PULSE_GEN_SELF_CORRECT_EN
    // Corrupted two-hot ring recovers to the reset phase in one edge.
    skip_cmp = 1'b1;
    @(negedge CLK);
    force dut.ring_q = 8'b0001_0010;
    #2;
    release dut.ring_q;
    corrupt = 1'b1;
    @(posedge CLK);
    #1;
    corrupt = 1'b0;
    check_lit("self_correct", 8'b0000_0001);
    skip_cmp = 1'b0;
    step(1'b0);
    check_lit("self_correct_next", 8'b0000_0010);
`endif

    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
